// File: rtl/task_2_down_counter.sv
// -----------------------------------------------------------------------------
// task_2_down_counter
//
// Loadable down-counter / timer. A start value is loaded, the count decrements
// by one on each enabled cycle, and expiry is flagged by the terminal-count
// output tc, which is high for the one cycle the FSM spends in EXPIRE.
// The timer is the counting-down partner of the loadable up-counter and is
// used as a programmable delay or timeout generator.
//
// Build option:
//   AUTO_RELOAD_EN  undefined -> one-shot: EXPIRE always returns to IDLE and
//                                cnt_out stays at 0.
//                   defined   -> periodic: the terminal decrement reloads the
//                                last loaded value, and EXPIRE counts exactly
//                                like RUN.
//
// Handshake: there is no valid/ready pair. load and enab are level controls
// sampled at every posedge, with priority rst > load > enab. cnt_in is only
// looked at when load=1.
//
// Ports:
//   clk      in   1      single clock, all state changes on posedge
//   rst      in   1      synchronous active-high reset, highest priority
//   load     in   1      load cnt_in into the counter (wins over enab)
//   enab     in   1      count enable, decrements by 1 per cycle in RUN
//   cnt_in   in   WIDTH  load value
//   cnt_out  out  WIDTH  current count (registered)
//   tc       out  1      terminal-count pulse, high only in EXPIRE
//   busy     out  1      high in RUN or EXPIRE (timer armed)
// -----------------------------------------------------------------------------
module task_2_down_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             enab,
    input  logic [WIDTH-1:0] cnt_in,
    output logic [WIDTH-1:0] cnt_out,
    output logic             tc,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        EXPIRE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ZERO = '0;

    state_t           state;
    logic [WIDTH-1:0] reload_val;

`ifdef AUTO_RELOAD_EN
    // The terminal decrement restarts the period from the last loaded value.
    localparam logic AUTO_RELOAD = 1'b1;
`else
    localparam logic AUTO_RELOAD = 1'b0;
`endif

    // What cnt_out becomes on the terminal decrement (1 -> expiry).
    logic [WIDTH-1:0] terminal_val;
    assign terminal_val = AUTO_RELOAD ? reload_val : ZERO;

    // tc and busy are registered together with the state, so they always
    // match the state the FSM is in (Moore outputs).
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt_out    <= ZERO;
            reload_val <= ZERO;
            tc         <= 1'b0;
            busy       <= 1'b0;
        end else if (load) begin
            cnt_out    <= cnt_in;
            reload_val <= cnt_in;
            // A zero load disarms the timer without any tc pulse.
            if (cnt_in != ZERO) begin
                state <= RUN;
                busy  <= 1'b1;
            end else begin
                state <= IDLE;
                busy  <= 1'b0;
            end
            tc <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // enab is ignored and the count holds.
                    tc   <= 1'b0;
                    busy <= 1'b0;
                end

                RUN: begin
                    busy <= 1'b1;
                    // cnt_out is never 0 in RUN (only reached via terminal
                    // or load), so no underflow path exists.
                    if (enab && cnt_out == ONE) begin
                        cnt_out <= terminal_val;
                        state   <= EXPIRE;
                        tc      <= 1'b1;
                    end else begin
                        if (enab && cnt_out > ONE) begin
                            cnt_out <= cnt_out - ONE;
                        end
                        tc <= 1'b0;
                    end
                end

                EXPIRE: begin
                    if (!AUTO_RELOAD) begin
                        // One-shot: leave after exactly one cycle, count
                        // stays at 0.
                        state <= IDLE;
                        tc    <= 1'b0;
                        busy  <= 1'b0;
                    end else begin
                        // Periodic: behave as RUN. A reload value of 1
                        // expires again on every enabled cycle, keeping
                        // the FSM (and tc) in EXPIRE.
                        busy <= 1'b1;
                        if (enab && cnt_out == ONE) begin
                            cnt_out <= terminal_val;
                            state   <= EXPIRE;
                            tc      <= 1'b1;
                        end else begin
                            if (enab && cnt_out > ONE) begin
                                cnt_out <= cnt_out - ONE;
                            end
                            state <= RUN;
                            tc    <= 1'b0;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                    tc    <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_task_2_down_counter.sv
module tb_task_2_down_counter;

  localparam int WIDTH = 4;

  // ---------------------------------------------------------------- clock/reset
  logic             clk;
  logic             rst;
  logic             load;
  logic             enab;
  logic [WIDTH-1:0] cnt_in;
  logic [WIDTH-1:0] cnt_out;
  logic             tc;
  logic             busy;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task_2_down_counter #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .enab    (enab),
    .cnt_in  (cnt_in),
    .cnt_out (cnt_out),
    .tc      (tc),
    .busy    (busy)
  );

`ifdef AUTO_RELOAD_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  int checks;
  int errors;

  // ---------------------------------------------------------------- checking
  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // ---------------------------------------------------------------- driver
  // Inputs change on the falling edge; outputs are sampled 1 time unit after
  // the rising edge that consumes them.
  task automatic drive(input bit r, input bit l, input bit e, input int v);
    @(negedge clk);
    rst    = r;
    load   = l;
    enab   = e;
    cnt_in = WIDTH'(v);
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------- reference model
  // Timer described in terms of the count, the last loaded value, whether it
  // is armed, and whether the previous edge was an expiry.
  int m_cnt, m_reload;
  bit m_armed, m_fired;

  task automatic model_step(input bit r, input bit l, input bit e, input int v);
    bit fire;
    fire = 1'b0;
    if (r) begin
      m_cnt = 0; m_reload = 0; m_armed = 0;
    end else if (l) begin
      m_cnt = v; m_reload = v; m_armed = (v != 0);
    end else if (m_fired && !AUTO) begin
      m_armed = 0;
    end else if (m_armed && e) begin
      if (m_cnt == 1) begin
        fire  = 1'b1;
        m_cnt = AUTO ? m_reload : 0;
      end else begin
        m_cnt = m_cnt - 1;
      end
    end
    m_fired = fire;
  endtask

  // ---------------------------------------------------------------- scoreboard
  logic [WIDTH+1:0] exp_q[$];  // {cnt, tc, busy}

  typedef struct {
    bit r; bit l; bit e; int v;
    int cnt; bit tc; bit busy;
    string name;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit r, bit l, bit e, int v, int c, bit t, bit b, string n);
    vec_t x;
    x.r = r; x.l = l; x.e = e; x.v = v; x.cnt = c; x.tc = t; x.busy = b; x.name = n;
    return x;
  endfunction

  initial begin
    logic [WIDTH+1:0] exp;
    checks = 0;
    errors = 0;
    rst = 1'b1; load = 1'b0; enab = 1'b0; cnt_in = '0;

`ifndef AUTO_RELOAD_EN
    // One-shot directed vectors: reset, countdown, pause, load priority,
    // zero load, rst priority, reload during EXPIRE.
    vecs.push_back(mk(1,1,1, 9,  0,0,0, "reset_arbitrary"));
    vecs.push_back(mk(0,0,1, 0,  0,0,0, "idle_enab_ignored"));
    vecs.push_back(mk(0,1,0, 5,  5,0,1, "load5"));
    vecs.push_back(mk(0,0,1, 0,  4,0,1, "dec4"));
    vecs.push_back(mk(0,0,1, 0,  3,0,1, "dec3"));
    vecs.push_back(mk(0,0,0, 0,  3,0,1, "pause1"));
    vecs.push_back(mk(0,0,0, 0,  3,0,1, "pause2"));
    vecs.push_back(mk(0,0,1, 0,  2,0,1, "resume2"));
    vecs.push_back(mk(0,0,1, 0,  1,0,1, "resume1"));
    vecs.push_back(mk(0,0,1, 0,  0,1,1, "expire_tc"));
    vecs.push_back(mk(0,0,1, 0,  0,0,0, "after_expire_idle"));
    vecs.push_back(mk(0,0,1, 0,  0,0,0, "idle_no_wrap"));
    vecs.push_back(mk(0,1,1, 4,  4,0,1, "load4"));
    vecs.push_back(mk(0,0,1, 0,  3,0,1, "dec3b"));
    vecs.push_back(mk(0,0,1, 0,  2,0,1, "dec2b"));
    vecs.push_back(mk(0,1,1, 13, 13,0,1, "load_wins_enab"));
    vecs.push_back(mk(0,0,1, 0,  12,0,1, "dec12"));
    vecs.push_back(mk(0,1,1, 0,  0,0,0, "load_zero_idle"));
    vecs.push_back(mk(0,0,1, 0,  0,0,0, "load_zero_no_tc"));
    vecs.push_back(mk(0,1,0, 7,  7,0,1, "load7"));
    vecs.push_back(mk(1,1,1, 3,  0,0,0, "rst_wins_load"));
    vecs.push_back(mk(0,0,1, 0,  0,0,0, "after_rst_idle"));
    vecs.push_back(mk(0,1,1, 1,  1,0,1, "load1"));
    vecs.push_back(mk(0,0,1, 0,  0,1,1, "load1_expire"));
    vecs.push_back(mk(0,1,0, 2,  2,0,1, "load_in_expire"));
    vecs.push_back(mk(0,0,1, 0,  1,0,1, "dec1c"));
    vecs.push_back(mk(0,0,0, 0,  0,1,1, "hold_expire_onecycle_pre"));
    // The previous row is intentionally corrected below: with enab=0 the
    // count pauses at 1, so it must not expire.
    vecs[vecs.size()-1] = mk(0,0,0, 0, 1,0,1, "pause_at_one");
    vecs.push_back(mk(0,0,1, 0,  0,1,1, "expire_c"));
    vecs.push_back(mk(0,0,0, 0,  0,0,0, "expire_ends_enab0"));

    foreach (vecs[i]) begin
      drive(vecs[i].r, vecs[i].l, vecs[i].e, vecs[i].v);
      check({vecs[i].name, ".cnt"},  int'(cnt_out), vecs[i].cnt);
      check({vecs[i].name, ".tc"},   int'(tc),      int'(vecs[i].tc));
      check({vecs[i].name, ".busy"}, int'(busy),    int'(vecs[i].busy));
    end
`else
    // Periodic: load 3 with enab held -> 3,2,1,3(tc),2,1,3(tc).
    begin
      int seq_cnt[7];
      bit seq_tc[7];
      seq_cnt = '{3,2,1,3,2,1,3};
      seq_tc  = '{0,0,0,1,0,0,1};
      drive(1,0,0,0);
      check("auto.reset_cnt", int'(cnt_out), 0);
      for (int i = 0; i < 7; i++) begin
        drive(0, i == 0, 1, 3);
        check($sformatf("auto.cnt%0d", i), int'(cnt_out), seq_cnt[i]);
        check($sformatf("auto.tc%0d", i),  int'(tc),      int'(seq_tc[i]));
        check($sformatf("auto.busy%0d", i), int'(busy),   1);
      end
      // enab=0 in EXPIRE: hold count, leave EXPIRE.
      drive(0,0,0,0);
      check("auto.hold_cnt", int'(cnt_out), 3);
      check("auto.hold_tc",  int'(tc),      0);
      // reload 1: tc stays high continuously.
      drive(0,1,1,1);
      for (int i = 0; i < 3; i++) begin
        drive(0,0,1,0);
        check($sformatf("auto.r1_tc%0d", i),  int'(tc),      1);
        check($sformatf("auto.r1_cnt%0d", i), int'(cnt_out), 1);
      end
    end
`endif

    // ------------------------------------------------------------ random phase
    drive(1,0,0,0);
    m_cnt = 0; m_reload = 0; m_armed = 0; m_fired = 0;
    for (int i = 0; i < 3000; i++) begin
      bit r, l, e;
      int v;
      r = ($urandom_range(0, 63) == 0);
      l = ($urandom_range(0, 9) == 0);
      e = ($urandom_range(0, 3) != 0);
      v = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 2) : $urandom_range(0, (1 << WIDTH) - 1);
      model_step(r, l, e, v);
      exp_q.push_back({WIDTH'(m_cnt), m_fired, m_armed});
      drive(r, l, e, v);
      exp = exp_q.pop_front();
      check("rand.cnt",  int'(cnt_out), int'(exp[WIDTH+1:2]));
      check("rand.tc",   int'(tc),      int'(exp[1]));
      check("rand.busy", int'(busy),    int'(exp[0]));
    end

    // ------------------------------------------------------------ report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
